// File: rtl/fifo_burst_reader.sv
// Pulls words from a synchronous FIFO in bursts of up to BURST_LEN and streams them
// out with first/last framing; an idle timer flushes partial bursts that wait too long.
module fifo_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int COUNT_W   = 6,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  fifo_data,
  input  logic               fifo_empty,
  input  logic [COUNT_W-1:0] fifo_count,
  output logic               fifo_rd_en,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_first,
  output logic               m_last,
  output logic               busy
);
  // state | meaning
  // IDLE  | no burst in progress; idle timer watches for a stale partial burst
  // READ  | issuing FIFO reads for the current burst
  // DRAIN | all reads issued; emptying the output buffer

  localparam int                 TMR_W     = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] BURST_CNT = COUNT_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [COUNT_W-1:0] burst_len_q, burst_len_d;
  logic [COUNT_W-1:0] reads_left_q, reads_left_d;
  logic               infl_q, infl_first_q, infl_last_q;
  entry_t             buf_q [3];
  entry_t             buf_d [3];
  logic [1:0]         occ_q, occ_d;
  logic [1:0]         occ_after_pop;
  logic               pop;
  logic               start_full;
  logic               start_timeout;
  logic               room_ok;
  entry_t             new_entry;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[0].data;
  assign m_first = buf_q[0].first;
  assign m_last  = buf_q[0].last;
  assign busy    = (state_q != IDLE);

  // occ + inflight must stay below the buffer depth so a returning word always fits
  assign room_ok    = (({1'b0, occ_q} + {2'b00, infl_q}) < 3'd3);
  assign fifo_rd_en = (state_q == READ) && (reads_left_q != '0) && !fifo_empty && room_ok;

  assign start_full    = (fifo_count >= BURST_CNT);
  assign start_timeout = (tmr_q == TMR_MAX) && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    burst_len_d  = burst_len_q;
    reads_left_d = reads_left_q;

    case (state_q)
      IDLE: begin
        if (start_full) begin
          state_d      = READ;
          burst_len_d  = BURST_CNT;
          reads_left_d = BURST_CNT;
          tmr_d        = '0;
        end else if (start_timeout) begin
          state_d      = READ;
          burst_len_d  = fifo_count;
          reads_left_d = fifo_count;
          tmr_d        = '0;
        end else if (fifo_empty) begin
          tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      READ: begin
        tmr_d = '0;
        if (reads_left_q == '0) begin
          state_d = DRAIN;
        end else if (fifo_rd_en) begin
          reads_left_d = reads_left_q - 1'b1;
        end
      end
      DRAIN: begin
        tmr_d = '0;
        if (pop && buf_q[0].last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Head-at-index-0 shift buffer; vacated slots are zeroed so idle outputs read 0.
  always_comb begin
    pop           = m_valid && m_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    new_entry     = {infl_first_q, infl_last_q, fifo_data};
    for (int i = 0; i < 3; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      buf_d[2] = '0;
    end
    if (infl_q) begin
      case (occ_after_pop)
        2'd0:    buf_d[0] = new_entry;
        2'd1:    buf_d[1] = new_entry;
        default: buf_d[2] = new_entry;
      endcase
    end
    occ_d = occ_after_pop + {1'b0, infl_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      burst_len_q  <= '0;
      reads_left_q <= '0;
      infl_q       <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      occ_q        <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      burst_len_q  <= burst_len_d;
      reads_left_q <= reads_left_d;
      infl_q       <= fifo_rd_en;
      infl_first_q <= fifo_rd_en && (reads_left_q == burst_len_q);
      infl_last_q  <= fifo_rd_en && (reads_left_q == COUNT_W'(1));
      occ_q        <= occ_d;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO plus a framing scoreboard built from
// the burst rules (full bursts of BURST_LEN, remainder flushed as one partial burst).
module tb_fifo_burst_reader;
  localparam int DATA_W  = 16;
  localparam int COUNT_W = 6;
  localparam int BL      = 8;
  localparam int TO      = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DATA_W-1:0]  fifo_data = '0;
  logic               fifo_empty = 1'b1;
  logic [COUNT_W-1:0] fifo_count = '0;
  logic               fifo_rd_en;
  logic [DATA_W-1:0]  m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               m_first;
  logic               m_last;
  logic               busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first), .m_last(m_last),
    .busy(busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] fq[$];
  logic [15:0] wq[$];
  logic [17:0] exp_q[$];
  int          rd_log[$];
  int          xf_log[$];
  bit          busy_at[int];
  int          rd_tot = 0;
  int          xf_tot = 0;
  bit          prev_stall = 1'b0;
  logic [18:0] prev_out = '0;
  bit          rd_s = 1'b0;
  bit          ready_plan = 1'b0;
  bit          rst_plan = 1'b1;
  bit          fifo_follow_rst = 1'b0;
  int          wr_cyc = 0;
  logic [17:0] e;
  logic [20:0] outs_w;

  assign outs_w = {fifo_rd_en, m_valid, m_first, m_last, busy, m_data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Words written into an idle, empty system: full bursts first, remainder last.
  task automatic push_vals(input logic [15:0] vals[$]);
    int n;
    n = vals.size();
    for (int i = 0; i < n; i++) begin
      wq.push_back(vals[i]);
      exp_q.push_back({((i % BL) == 0), (((i % BL) == BL - 1) || (i == n - 1)), vals[i]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst && fifo_follow_rst) begin
      fq.delete();
      fifo_data = '0;
    end else if (rd_s && fq.size() != 0) begin
      fifo_data = fq.pop_front();
    end
    if (wq.size() != 0) begin
      wr_cyc = cyc + 1;
      while (wq.size() != 0) fq.push_back(wq.pop_front());
    end
    fifo_count = COUNT_W'(fq.size());
    fifo_empty = (fq.size() == 0);
    m_ready    = ready_plan;
    rst        = rst_plan;
    @(negedge clk);
    cyc++;
    busy_at[cyc] = busy;
    rd_s = 1'b0;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        chk("rd_while_empty", 32'(fifo_empty), 32'(0));
        chk("rd_buffer_budget", 32'((rd_tot - xf_tot) < 3), 32'(1));
        rd_log.push_back(cyc);
        rd_tot++;
        rd_s = 1'b1;
      end
      if (prev_stall) chk("stall_hold", 32'({m_valid, m_first, m_last, m_data}), 32'(prev_out));
      if (m_valid && m_ready) begin
        chk("xfer_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("xfer_word", 32'({m_first, m_last, m_data}), 32'(e));
        end
        xf_log.push_back(cyc);
        xf_tot++;
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_first, m_last, m_data};
    end
  endtask

  // mode 0: ready high, 1: alternating, 2: random (~75% high)
  task automatic wait_done(input string tag, input int budget, input int mode);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || fq.size() != 0 || wq.size() != 0) && n < budget) begin
      case (mode)
        0:       ready_plan = 1'b1;
        1:       ready_plan = ~ready_plan;
        default: ready_plan = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'(1));
  endtask

  initial begin
    logic [15:0] v[$];
    int base_rd, base_xf, rel, n, last_xf;

    // reset held two cycles with three words already in the FIFO
    v = '{16'h0044, 16'h007B, 16'h0035};
    push_vals(v);
    tick();
    chk("reset_outputs_c1", 32'(outs_w), 32'(0));
    rst_plan = 1'b0;
    tick();
    chk("reset_outputs_c2", 32'(outs_w), 32'(0));
    rel = cyc;
    fifo_follow_rst = 1'b1;

    // timer counts 0..TO-1 from the first idle cycle, then the burst starts
    wait_done("timeout_done", 300, 0);
    chk("timeout_first_rd", 32'(rd_log[0]), 32'(rel + TO));
    chk("timeout_rd_count", 32'(rd_log.size()), 32'(3));

    // full burst with the sink always ready
    base_rd = rd_log.size();
    base_xf = xf_log.size();
    v.delete();
    for (int i = 1; i <= 8; i++) v.push_back(16'(i));
    push_vals(v);
    wait_done("full_done", 200, 0);
    last_xf = xf_log[base_xf + 7];
    chk("full_rd_count", 32'(rd_log.size() - base_rd), 32'(8));
    chk("full_first_rd", 32'(rd_log[base_rd]), 32'(wr_cyc + 1));
    chk("full_latency", 32'(xf_log[base_xf]), 32'(rd_log[base_rd] + 2));
    chk("full_consecutive", 32'(last_xf - xf_log[base_xf]), 32'(7));
    chk("full_busy_at_last", 32'(busy_at[last_xf]), 32'(1));
    chk("full_busy_drop", 32'(busy_at[last_xf + 1]), 32'(0));

    // backpressure: ten stalled cycles, then alternating ready
    base_rd = rd_log.size();
    v.delete();
    for (int i = 1; i <= 8; i++) v.push_back(16'(i));
    push_vals(v);
    ready_plan = 1'b0;
    repeat (11) tick();
    chk("bp_rd_stop", 32'(rd_log.size() - base_rd), 32'(3));
    chk("bp_valid_held", 32'(m_valid), 32'(1));
    wait_done("bp_done", 300, 1);
    chk("bp_rd_total", 32'(rd_log.size() - base_rd), 32'(8));

    // 20 words: bursts of 8, 8, then a timeout burst of 4
    base_rd = rd_log.size();
    v.delete();
    for (int i = 0; i < 20; i++) v.push_back(16'($urandom));
    push_vals(v);
    wait_done("multi_done", 1500, 2);
    chk("multi_rd_total", 32'(rd_log.size() - base_rd), 32'(20));

    // single word: first and last on the same beat
    v = '{16'hA5A5};
    push_vals(v);
    wait_done("single_done", 300, 0);

    // reset after the third transfer of an 8-word burst
    base_xf = xf_log.size();
    v.delete();
    for (int i = 0; i < 8; i++) v.push_back(16'h0100 + 16'(i));
    push_vals(v);
    n = 0;
    while ((xf_log.size() - base_xf) < 3 && n < 50) begin
      ready_plan = 1'b1;
      tick();
      n++;
    end
    chk("mid_third_xfer", 32'(n < 50), 32'(1));
    rst_plan = 1'b1;
    tick();
    exp_q.delete();
    rd_tot = 0;
    xf_tot = 0;
    prev_stall = 1'b0;
    rst_plan = 1'b0;
    tick();
    chk("mid_outputs_zero", 32'(outs_w), 32'(0));
    base_rd = rd_log.size();
    repeat (TO + 16) tick();
    chk("mid_no_rd", 32'(rd_log.size() - base_rd), 32'(0));

    // recovery and randomized batches
    v.delete();
    for (int i = 0; i < 8; i++) v.push_back(16'h0200 + 16'(i));
    push_vals(v);
    wait_done("recover_done", 200, 0);
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 30);
      base_rd = rd_log.size();
      v.delete();
      for (int i = 0; i < n; i++) v.push_back(16'($urandom));
      push_vals(v);
      wait_done("rand_done", 2000, 2);
      chk("rand_rd_total", 32'(rd_log.size() - base_rd), 32'(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
